// File: rtl/gemm_sched_pkg.sv
// Shared definitions for the GEMM tile scheduler: default widths and FSM state encoding.
package gemm_sched_pkg;

   localparam int DEF_DIM_W = 16;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_REQ,
      S_LD_WAIT,
      S_CMP,
      S_CMP_WAIT,
      S_ST_REQ,
      S_ST_WAIT,
      S_FIN
   } sched_state_t;

endpackage

// File: rtl/gemm_tile_scheduler_idx.sv
// Nested tile index counter: k innermost, then n, then m outermost.
module tile_idx_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc_k,
   input  logic         inc_mn,
   input  logic [W-1:0] dim_m,
   input  logic [W-1:0] dim_n,
   input  logic [W-1:0] dim_k,
   output logic [W-1:0] idx_m,
   output logic [W-1:0] idx_n,
   output logic [W-1:0] idx_k,
   output logic         last_k,
   output logic         last_tile
);

   logic [W-1:0] r_m, r_n, r_k;
   logic         w_last_m, w_last_n;

   assign w_last_m  = (r_m == dim_m - W'(1));
   assign w_last_n  = (r_n == dim_n - W'(1));
   assign last_k    = (r_k == dim_k - W'(1));
   assign last_tile = w_last_m && w_last_n;

   // After the final tile n wraps to 0 while m parks on its last row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m <= '0;
         r_n <= '0;
         r_k <= '0;
      end else if (clr) begin
         r_m <= '0;
         r_n <= '0;
         r_k <= '0;
      end else if (inc_mn) begin
         r_k <= '0;
         if (!w_last_n) begin
            r_n <= r_n + W'(1);
         end else begin
            r_n <= '0;
            if (!w_last_m) r_m <= r_m + W'(1);
         end
      end else if (inc_k) begin
         r_k <= r_k + W'(1);
      end
   end

   assign idx_m = r_m;
   assign idx_n = r_n;
   assign idx_k = r_k;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Sequences load / compute / store handshakes over an mt x nt x kt tile job.
module gemm_tile_scheduler
   import gemm_sched_pkg::*;
#(
   parameter int DIM_W = DEF_DIM_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIM_W-1:0] cfg_mt,
   input  logic [DIM_W-1:0] cfg_nt,
   input  logic [DIM_W-1:0] cfg_kt,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [DIM_W-1:0] tile_m,
   output logic [DIM_W-1:0] tile_n,
   output logic [DIM_W-1:0] tile_k,
   output logic             ld_valid,
   input  logic             ld_ready,
   input  logic             ld_done,
   output logic             cmp_start,
   output logic             cmp_clr,
   input  logic             cmp_done,
   output logic             st_valid,
   input  logic             st_ready,
   input  logic             st_done,
   output logic [CNT_W-1:0] cyc_cnt
);

   sched_state_t     r_state, w_state_next;
   logic [DIM_W-1:0] r_mt, r_nt, r_kt;
   logic             r_busy, r_done, r_err;
   logic             r_ld_valid, r_cmp_start, r_cmp_clr, r_st_valid;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic             w_cfg_zero, w_clr, w_inc_k, w_inc_mn, w_err_next;
   logic             w_last_k, w_last_tile;
   logic [DIM_W-1:0] w_tile_m, w_tile_n, w_tile_k;

   assign w_cfg_zero = (cfg_mt == '0) || (cfg_nt == '0) || (cfg_kt == '0);

   tile_idx_counter #(.W(DIM_W)) u_idx (
      .clk       (clk),
      .rst       (rst),
      .clr       (w_clr),
      .inc_k     (w_inc_k),
      .inc_mn    (w_inc_mn),
      .dim_m     (r_mt),
      .dim_n     (r_nt),
      .dim_k     (r_kt),
      .idx_m     (w_tile_m),
      .idx_n     (w_tile_n),
      .idx_k     (w_tile_k),
      .last_k    (w_last_k),
      .last_tile (w_last_tile)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mt <= '0;
         r_nt <= '0;
         r_kt <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_mt <= cfg_mt;
         r_nt <= cfg_nt;
         r_kt <= cfg_kt;
      end
   end

   // abort wins over every handshake and done input in a busy state.
   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_inc_k      = 1'b0;
      w_inc_mn     = 1'b0;
      w_err_next   = 1'b0;
      if (r_state != S_IDLE && abort) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_cfg_zero) begin
                     w_err_next = 1'b1;
                  end else begin
                     w_clr        = 1'b1;
                     w_state_next = S_LD_REQ;
                  end
               end
            end
            S_LD_REQ:  if (ld_ready) w_state_next = S_LD_WAIT;
            S_LD_WAIT: if (ld_done)  w_state_next = S_CMP;
            S_CMP:     w_state_next = S_CMP_WAIT;
            S_CMP_WAIT: begin
               if (cmp_done) begin
                  if (!w_last_k) begin
                     w_inc_k      = 1'b1;
                     w_state_next = S_LD_REQ;
                  end else begin
                     w_state_next = S_ST_REQ;
                  end
               end
            end
            S_ST_REQ:  if (st_ready) w_state_next = S_ST_WAIT;
            S_ST_WAIT: begin
               if (st_done) begin
                  w_inc_mn     = 1'b1;
                  w_state_next = w_last_tile ? S_FIN : S_LD_REQ;
               end
            end
            S_FIN:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they change only on clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_ld_valid  <= 1'b0;
         r_cmp_start <= 1'b0;
         r_cmp_clr   <= 1'b0;
         r_st_valid  <= 1'b0;
         r_cyc_cnt   <= '0;
      end else begin
         r_busy      <= (w_state_next != S_IDLE);
         r_done      <= (w_state_next == S_FIN);
         r_err       <= w_err_next;
         r_ld_valid  <= (w_state_next == S_LD_REQ);
         r_cmp_start <= (w_state_next == S_CMP);
         r_cmp_clr   <= (w_state_next == S_CMP) && (w_tile_k == '0);
         r_st_valid  <= (w_state_next == S_ST_REQ);
         if (w_clr) begin
            r_cyc_cnt <= '0;
         end else if (r_state != S_IDLE && r_cyc_cnt != '1) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign ld_valid  = r_ld_valid;
   assign cmp_start = r_cmp_start;
   assign cmp_clr   = r_cmp_clr;
   assign st_valid  = r_st_valid;
   assign cyc_cnt   = r_cyc_cnt;
   assign tile_m    = w_tile_m;
   assign tile_n    = w_tile_n;
   assign tile_k    = w_tile_k;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Randomized bench for gemm_tile_scheduler: a transaction-level job model drives
// the handshake engines and checks every output each cycle.
module tb_gemm_tile_scheduler;

   localparam int DW = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] cfg_mt, cfg_nt, cfg_kt;
   logic          start, abort, ld_ready, ld_done, cmp_done, st_ready, st_done;
   logic          busy, done, err, ld_valid, cmp_start, cmp_clr, st_valid;
   logic [DW-1:0] tile_m, tile_n, tile_k;
   logic [CW-1:0] cyc_cnt;

   always #5 clk = ~clk;

   gemm_tile_scheduler #(.DIM_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cfg_mt(cfg_mt), .cfg_nt(cfg_nt), .cfg_kt(cfg_kt),
      .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
      .cmp_start(cmp_start), .cmp_clr(cmp_clr), .cmp_done(cmp_done),
      .st_valid(st_valid), .st_ready(st_ready), .st_done(st_done),
      .cyc_cnt(cyc_cnt)
   );

   typedef struct {int m; int n; int k;} idx_t;
   idx_t ld_q[$], cmp_q[$], st_q[$];

   int checks = 0;
   int errors = 0;
   // model: act = job in flight; *_req = request owed; pend_* = engine working
   bit act, ld_req, st_req, pend_ld, pend_cmp, pend_st;
   bit ld_done_prev, done_exp, err_exp, st_is_last, cmp_is_last, st_hold;
   int cnt_exp, cyc_idx, start_cyc, done_cyc, job_kt;
   int n_ld, n_cmp, n_clr, n_st, n_done, n_err;
   int rdy_pct, done_pct, spur_pct, stall_left, abort_at;

   task automatic chk(input string name, input longint a, input longint e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, e, cyc_idx);
      end
   endtask

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   task automatic build(input int mt, input int nt, input int kt);
      ld_q.delete(); cmp_q.delete(); st_q.delete();
      for (int m = 0; m < mt; m++)
         for (int n = 0; n < nt; n++) begin
            for (int k = 0; k < kt; k++) begin
               ld_q.push_back('{m, n, k});
               cmp_q.push_back('{m, n, k});
            end
            st_q.push_back('{m, n, 0});
         end
   endtask

   task automatic model_clear();
      act = 0; ld_req = 0; st_req = 0; pend_ld = 0; pend_cmp = 0; pend_st = 0;
      ld_done_prev = 0; done_exp = 0; err_exp = 0;
   endtask

   task automatic step(input bit do_start, input bit do_abort);
      idx_t f;
      bit ab, r_ld, r_cmp, r_st, act_now, new_ld, new_st, new_cmp;
      @(negedge clk);
      cyc_idx++;
      act_now = act;
      new_ld = 0; new_st = 0; new_cmp = 0;
      chk("busy", busy, act);
      chk("cyc_cnt", cyc_cnt, cnt_exp);
      if (act) cnt_exp++;
      chk("err", err, err_exp);
      if (err) n_err++;
      err_exp = 0;
      chk("done", done, done_exp);
      if (done) begin n_done++; done_cyc = cyc_idx; end
      if (done_exp) begin act = 0; done_exp = 0; end
      chk("cmp_start", cmp_start, ld_done_prev);
      if (cmp_start && cmp_q.size() > 0) begin
         f = cmp_q.pop_front();
         chk("cmp_m", tile_m, f.m); chk("cmp_n", tile_n, f.n); chk("cmp_k", tile_k, f.k);
         chk("cmp_clr", cmp_clr, f.k == 0);
         n_cmp++;
         if (cmp_clr) n_clr++;
         cmp_is_last = (f.k == job_kt - 1);
         new_cmp = 1;
      end else begin
         chk("cmp_clr_idle", cmp_clr, 0);
      end
      ld_done_prev = 0;
      chk("ld_valid", ld_valid, ld_req);
      if (ld_valid && ld_req && ld_q.size() > 0) begin
         f = ld_q[0];
         chk("ld_m", tile_m, f.m); chk("ld_n", tile_n, f.n); chk("ld_k", tile_k, f.k);
      end
      chk("st_valid", st_valid, st_req);
      if (st_valid && st_req && st_q.size() > 0) begin
         f = st_q[0];
         chk("st_m", tile_m, f.m); chk("st_n", tile_n, f.n);
      end

      r_ld  = pend_ld && pct(done_pct);
      r_cmp = pend_cmp && pct(done_pct);
      r_st  = pend_st && !st_hold && pct(done_pct);
      ab    = do_abort && act_now;
      if (pend_cmp && abort_at >= 0 && n_cmp == abort_at) begin r_cmp = 1; ab = 1; end
      ld_done  = pend_ld  ? r_ld  : pct(spur_pct);
      cmp_done = pend_cmp ? r_cmp : pct(spur_pct);
      st_done  = pend_st  ? r_st  : pct(spur_pct);
      if (stall_left > 0 && ld_req) begin
         ld_ready = 0;
         stall_left--;
      end else begin
         ld_ready = pct(rdy_pct);
      end
      st_ready = pct(rdy_pct);
      start    = do_start;
      abort    = ab;

      if (ab) begin
         model_clear();
         abort_at = -1;
      end else if (act_now) begin
         if (ld_req && ld_ready) begin
            ld_req = 0; n_ld++; new_ld = 1;
            if (ld_q.size() > 0) void'(ld_q.pop_front());
         end
         if (st_req && st_ready) begin
            st_req = 0; n_st++; new_st = 1;
            if (st_q.size() > 0) void'(st_q.pop_front());
            st_is_last = (st_q.size() == 0);
         end
         if (r_ld)  begin pend_ld = 0; ld_done_prev = 1; end
         if (r_cmp) begin pend_cmp = 0; if (cmp_is_last) st_req = 1; else ld_req = 1; end
         if (r_st)  begin pend_st = 0; if (st_is_last) done_exp = 1; else ld_req = 1; end
         pend_ld  = pend_ld  || new_ld;
         pend_st  = pend_st  || new_st;
         pend_cmp = pend_cmp || new_cmp;
      end
      if (do_start && !act_now) begin
         if (cfg_mt == 0 || cfg_nt == 0 || cfg_kt == 0) begin
            err_exp = 1;
         end else begin
            act = 1; cnt_exp = 0; ld_req = 1; start_cyc = cyc_idx; job_kt = int'(cfg_kt);
            build(int'(cfg_mt), int'(cfg_nt), int'(cfg_kt));
         end
      end
   endtask

   task automatic run_job(input int mt, input int nt, input int kt, input bit rnd_start);
      int guard;
      bit aborting;
      n_ld = 0; n_cmp = 0; n_clr = 0; n_st = 0; n_done = 0; n_err = 0;
      aborting = (abort_at >= 0);
      cfg_mt = DW'(mt); cfg_nt = DW'(nt); cfg_kt = DW'(kt);
      step(1, 0);
      guard = 0;
      while (act && guard < 4000) begin
         step(rnd_start ? pct(5) : 1'b0, 0);
         guard++;
      end
      chk("job_timeout", guard < 4000, 1);
      step(0, 0);
      if (aborting) begin
         chk("abort_no_done", n_done, 0);
      end else if (mt > 0 && nt > 0 && kt > 0) begin
         chk("n_loads", n_ld, mt * nt * kt);
         chk("n_cmps", n_cmp, mt * nt * kt);
         chk("n_clr", n_clr, mt * nt);
         chk("n_stores", n_st, mt * nt);
         chk("n_done", n_done, 1);
      end
   endtask

   task automatic set_hs(input int rdy, input int dn, input int sp);
      rdy_pct = rdy; done_pct = dn; spur_pct = sp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; start = 0; abort = 0; ld_ready = 0; ld_done = 0; cmp_done = 0;
      st_ready = 0; st_done = 0; cfg_mt = 0; cfg_nt = 0; cfg_kt = 0;
      model_clear();
      cnt_exp = 0; cyc_idx = 0; stall_left = 0; abort_at = -1; st_hold = 0;
      set_hs(100, 100, 0);
      #1;
      chk("rst_busy", busy, 0); chk("rst_ld_valid", ld_valid, 0);
      chk("rst_cyc", cyc_cnt, 0); chk("rst_done", done, 0);
      repeat (2) @(negedge clk);
      #2 rst = 0;

      // all handshakes tied high, single tile
      set_hs(100, 100, 100);
      run_job(1, 1, 1, 0);
      chk("t1_cyc_cnt", cyc_cnt, 7);
      chk("t1_done_latency", done_cyc - start_cyc, 7);

      run_job(2, 2, 3, 0);
      chk("t2_cyc_cnt", cyc_cnt, 57);

      // ld_ready withheld for 5 request cycles
      set_hs(100, 100, 0);
      stall_left = 5;
      run_job(1, 1, 2, 0);
      chk("t3_stall_used", stall_left, 0);
      chk("t3_cyc_cnt", cyc_cnt, 16);

      // zero dimension
      run_job(2, 2, 0, 0);
      chk("t4_err_pulses", n_err, 1);
      chk("t4_loads", n_ld, 0);
      chk("t4_cyc_held", cyc_cnt, 16);

      // abort together with cmp_done, then a fresh job
      set_hs(70, 60, 20);
      abort_at = 5;
      run_job(2, 2, 3, 0);
      chk("t5_abort_hit", abort_at, -1);
      run_job(1, 2, 2, 1);

      for (int j = 0; j < 8; j++) begin
         set_hs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 20);
         run_job(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)),
                 int'($urandom_range(3, 1)), 1);
      end

      // asynchronous reset while waiting on st_done
      set_hs(100, 100, 0);
      st_hold = 1;
      cfg_mt = 1; cfg_nt = 1; cfg_kt = 1;
      n_done = 0;
      step(1, 0);
      for (int g = 0; g < 50 && !pend_st; g++) step(0, 0);
      step(0, 0);
      chk("t6_in_st_wait", pend_st, 1);
      #2 rst = 1;
      #1;
      chk("t6_busy", busy, 0); chk("t6_ld_valid", ld_valid, 0);
      chk("t6_st_valid", st_valid, 0); chk("t6_cmp_start", cmp_start, 0);
      chk("t6_done", done, 0); chk("t6_cyc", cyc_cnt, 0);
      chk("t6_tile_m", tile_m, 0);
      model_clear();
      cnt_exp = 0; st_hold = 0;
      set_hs(100, 100, 100);
      step(0, 0);
      step(0, 0);
      #2 rst = 0;
      repeat (4) step(0, 0);
      chk("t6_no_done", n_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
